never_scan_ctrl: RTL and testbench

//  Sequencer for the nibble never-compare datapath. It scans a stream of up to
//  MAX_WORDS data words against one 4-bit pattern/mask. Results: total nibble-match

---
 rtl/never_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_never_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/never_scan_ctrl.sv
// Nibble never-compare scan sequencer: IDLE -> SCAN -> DONE, start/done command, valid/ready words.
// Optional NEVER_SCAN_EARLY_EXIT_EN: the first hit word ends the scan.
`timescale 1ns/1ps

module never_compare #(
    parameter int WIDTH = 32,
    localparam int NIB = WIDTH / 4
) (
    input  logic [WIDTH-1:0] word,
    input  logic [3:0]       pattern,
    input  logic [3:0]       mask,
    output logic [NIB-1:0]   out_mask,
    output logic             zero
);
    always_comb begin
        out_mask = '0;
        for (int i = 0; i < NIB; i++) begin
            out_mask[i] = ((word[4*i +: 4] & mask) == pattern);
        end
    end

    assign zero = ~|out_mask;
endmodule

// state | meaning
// IDLE  | waiting for start
// SCAN  | accepting words, accumulating results
// DONE  | scan finished; done pulses the following cycle
module never_scan_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 256,
    localparam int NIB      = WIDTH / 4,
    localparam int LEN_W    = $clog2(MAX_WORDS + 1),
    localparam int IDX_W    = $clog2(MAX_WORDS * WIDTH / 4),
    localparam int CNT_W    = $clog2(MAX_WORDS * WIDTH / 4 + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       pattern,
    input  logic [3:0]       mask,
    input  logic [LEN_W-1:0] length,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_data,
    output logic             word_ready,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] first_idx,
    output logic [CNT_W-1:0] match_count
);
    localparam int LOW_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_d;
    logic [3:0]       pat_q, mask_q;
    logic [LEN_W-1:0] rem, widx, len_c;
    logic [NIB-1:0]   out_mask;
    logic             zero, xfer, start_acc, early_stop;
    logic [CNT_W-1:0] hit_cnt;
    logic [LOW_W-1:0] low;

    never_compare #(.WIDTH(WIDTH)) u_cmp (
        .word     (word_data),
        .pattern  (pat_q),
        .mask     (mask_q),
        .out_mask (out_mask),
        .zero     (zero)
    );

    // done lands one cycle after DONE, so busy is stretched over the pulse
    assign busy      = (state != IDLE) | done;
    assign start_acc = start & ~busy;
    assign xfer      = word_valid & word_ready;
    assign len_c     = (length > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : length;

`ifdef NEVER_SCAN_EARLY_EXIT_EN
    assign early_stop = ~found & ~zero;
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NIB; i++) begin
            hit_cnt = hit_cnt + CNT_W'(out_mask[i]);
        end
    end

    always_comb begin
        low = '0;
        for (int i = NIB - 1; i >= 0; i--) begin
            if (out_mask[i]) low = LOW_W'(i);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start_acc) state_d = (len_c == '0) ? DONE : SCAN;
            SCAN: if (xfer && (rem == LEN_W'(1) || early_stop)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            word_ready  <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            first_idx   <= '1;
            match_count <= '0;
            pat_q       <= '0;
            mask_q      <= '0;
            rem         <= '0;
            widx        <= '0;
        end else begin
            state      <= state_d;
            word_ready <= (state_d == SCAN);
            done       <= (state == DONE);
            if (start_acc) begin
                pat_q       <= pattern;
                mask_q      <= mask;
                rem         <= len_c;
                widx        <= '0;
                found       <= 1'b0;
                first_idx   <= '1;
                match_count <= '0;
            end else if (xfer) begin
                match_count <= match_count + hit_cnt;
                rem         <= rem - 1'b1;
                widx        <= widx + 1'b1;
                if (!found && !zero) begin
                    found     <= 1'b1;
                    first_idx <= IDX_W'(widx) * IDX_W'(NIB) + IDX_W'(low);
                end
            end
        end
    end
endmodule

// File: tb/tb_never_scan_ctrl.sv
// Scoreboard bench for never_scan_ctrl: stimulus pushes expected results, a done monitor pops and compares.
`timescale 1ns/1ps

module tb_never_scan_ctrl;
    localparam int WIDTH     = 32;
    localparam int MAX_WORDS = 256;
    localparam int NIB       = WIDTH / 4;
    localparam int LEN_W     = $clog2(MAX_WORDS + 1);
    localparam int IDX_W     = $clog2(MAX_WORDS * WIDTH / 4);
    localparam int CNT_W     = $clog2(MAX_WORDS * WIDTH / 4 + 1);
`ifdef NEVER_SCAN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, start, word_valid;
    logic [3:0]       pattern, mask;
    logic [LEN_W-1:0] length;
    logic [WIDTH-1:0] word_data;
    logic             word_ready, busy, done, found;
    logic [IDX_W-1:0] first_idx;
    logic [CNT_W-1:0] match_count;

    never_scan_ctrl #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .mask(mask),
        .length(length), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .busy(busy), .done(done), .found(found),
        .first_idx(first_idx), .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] words [MAX_WORDS];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: every done pulse must match the oldest outstanding expectation
    initial forever begin
        @(negedge clk);
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("found", found, e.found);
                check("first_idx", first_idx, e.idx);
                check("match_count", match_count, e.cnt);
            end
        end
    end

    function automatic exp_t model(input logic [3:0] p, input logic [3:0] m, input int len);
        exp_t r;
        int   l;
        r.found = 1'b0;
        r.idx   = '1;
        r.cnt   = '0;
        l = (len > MAX_WORDS) ? MAX_WORDS : len;
        for (int w = 0; w < l; w++) begin
            for (int n = 0; n < NIB; n++) begin
                logic [WIDTH-1:0] wd;
                wd = words[w];
                if ((wd[4*n +: 4] & m) == p) begin
                    r.cnt++;
                    if (!r.found) begin
                        r.found = 1'b1;
                        r.idx   = IDX_W'(w * NIB + n);
                    end
                end
            end
            if (EARLY && r.found) break;
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic f, input int idx, input int cnt);
        exp_t r;
        r.found = f;
        r.idx   = IDX_W'(idx);
        r.cnt   = CNT_W'(cnt);
        return r;
    endfunction

    task automatic run_scan(input string name, input logic [3:0] p, input logic [3:0] m,
                            input int len_in, input int n_words, input bit gaps,
                            input bit spam, input int exp_lat);
        int idx = 0;
        int budget = 0;
        int ready_seen = 0;
        int c0;
        bit got = 0;
        @(posedge clk); #1;
        start = 1'b1; pattern = p; mask = m; length = LEN_W'(len_in);
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got && budget < 3000) begin
            word_valid = (idx < n_words) && (!gaps || $urandom_range(0, 2) != 0);
            word_data  = (idx < n_words) ? words[idx] : '0;
            if (spam) begin
                start   = 1'($urandom_range(0, 1));
                pattern = 4'($urandom);
                mask    = 4'($urandom);
                length  = LEN_W'($urandom);
            end
            @(negedge clk);
            if (word_ready) ready_seen++;
            if (word_valid && word_ready) idx++;
            if (done) begin
                got = 1;
                if (exp_lat >= 0) check({name, "_latency"}, cyc - c0, exp_lat);
            end else begin
                @(posedge clk); #1;
                budget++;
            end
        end
        start      = 1'b0;
        word_valid = 1'b0;
        if (!got) check({name, "_timeout"}, 0, 1);
        if (len_in == 0) check({name, "_no_ready"}, ready_seen, 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int idx;
        int budget;
        reset = 1'b1; start = 1'b0; pattern = '0; mask = '0; length = '0;
        word_valid = 1'b0; word_data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", word_ready, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_count", match_count, 0);
        check("rst_first_idx", first_idx, {IDX_W{1'b1}});
        reset = 1'b0;

        // T1: reset after three transferred words
        for (int i = 0; i < MAX_WORDS; i++) words[i] = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        start = 1'b1; pattern = 4'hA; mask = 4'hF; length = LEN_W'(10);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; budget = 0;
        word_valid = 1'b1; word_data = words[0];
        while (idx < 3 && budget < 100) begin
            @(negedge clk);
            if (word_valid && word_ready) idx++;
            budget++;
        end
        check("t1_words", idx, 3);
        reset = 1'b1;
        word_valid = 1'b0;
        @(negedge clk);
        check("t1_busy", busy, 0);
        check("t1_ready", word_ready, 0);
        check("t1_count", match_count, 0);
        check("t1_found", found, 0);
        check("t1_first_idx", first_idx, {IDX_W{1'b1}});
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // T2: zero length
        exp_q.push_back(mk(1'b0, (1 << IDX_W) - 1, 0));
        run_scan("t2", 4'hA, 4'hF, 0, 0, 0, 0, 2);

        // T3: directed three-word stream
        words[0] = 32'h0; words[1] = 32'h00A0_00A0; words[2] = 32'hAAAA_AAAA;
        exp_q.push_back(mk(1'b1, 9, EARLY ? 2 : 10));
        run_scan("t3", 4'hA, 4'hF, 3, 3, 0, 0, EARLY ? 4 : 5);

        // T4: everything matches, full length
        for (int i = 0; i < MAX_WORDS; i++) words[i] = $urandom;
        exp_q.push_back(mk(1'b1, 0, EARLY ? NIB : MAX_WORDS * NIB));
        run_scan("t4", 4'h0, 4'h0, MAX_WORDS, MAX_WORDS, 0, 0, EARLY ? 3 : MAX_WORDS + 2);

        // T6: unmatchable pattern/mask
        exp_q.push_back(mk(1'b0, (1 << IDX_W) - 1, 0));
        run_scan("t6", 4'h1, 4'hE, 5, 5, 0, 0, 7);

        // T5: valid gaps with start pulses while busy
        for (int k = 0; k < 4; k++) begin
            logic [3:0] p;
            int         len;
            for (int i = 0; i < MAX_WORDS; i++) words[i] = $urandom & 32'h7777_7777;
            p   = 4'h5;
            len = 3 + 2 * k;
            if (k == 3) words[len - 1] = 32'h0000_5000;
            for (int i = 0; i < len - 1 && k == 3; i++) words[i] = 32'h0;
            exp_q.push_back(model(p, 4'h7, len));
            run_scan("t5", p, 4'h7, len, len, 1, 1, -1);
        end

        // length above MAX_WORDS clamps
        for (int i = 0; i < MAX_WORDS; i++) words[i] = $urandom;
        exp_q.push_back(model(4'h3, 4'hF, 300));
        run_scan("clamp", 4'h3, 4'hF, 300, MAX_WORDS, 0, 0, -1);

        check("pending_expect", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
